// File: rtl/seg_scan_display_if.sv
// Bus bundle between user logic and the seven-segment scan driver.
//
// Signal semantics: there is no valid/ready handshake on this bus.
// data_in, dp_in and digit_en are level inputs that the driver may sample on
// any clock. load is a single-cycle strobe: on every clock where load=1, the
// driver captures data_in/dp_in into its pending buffer unconditionally. There
// is no backpressure. SEG/AN are registered pin-level outputs.
interface seg_scan_display_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] data_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    load;
   logic [7:0]              SEG;
   logic [NUM_DIGITS-1:0]   AN;

   // User side: supplies values, observes pins
   modport master (
      output data_in, dp_in, digit_en, load,
      input  SEG, AN
   );

   // Driver side
   modport slave (
      input  data_in, dp_in, digit_en, load,
      output SEG, AN
   );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment display driver.
// Each digit gets a slot of SCAN_DIV cycles; the first GAP_CYC cycles of every
// slot are blanked to suppress ghosting. New values are captured into a pending
// buffer on load and copied into the display buffer only at slot boundaries,
// so a digit never changes mid-slot.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_display #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int GAP_CYC    = 1000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_scan_display_if.slave     bus,
   output logic                  dbg_state_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BUF_W = 5 * NUM_DIGITS;
   localparam int DAT_W = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]      GAP_END  = CNT_W'(GAP_CYC);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

   // Slot phase: GAP blanks everything, SHOW lights the current digit
   typedef enum logic {
      ST_GAP  = 1'b0,
      ST_SHOW = 1'b1
   } phase_e;

   localparam phase_e ST_FIRST = (GAP_CYC > 0) ? ST_GAP : ST_SHOW;

   logic [CNT_W-1:0]      cnt_q,  cnt_d;
   logic [IDX_W-1:0]      idx_q,  idx_d;
   phase_e                state_q, state_d;
   logic [BUF_W-1:0]      pend_q, pend_d;
   logic [BUF_W-1:0]      disp_q, disp_d;
   logic [7:0]            seg_q,  seg_d;
   logic [NUM_DIGITS-1:0] an_q,   an_d;

   logic                  slot_end;
   logic [DAT_W-1:0]      disp_data;
   logic [NUM_DIGITS-1:0] disp_dp;
   logic [3:0]            cur_nib;
   logic [7:0]            seg_lit;
   logic [NUM_DIGITS-1:0] an_lit;

   // Hex nibble to segments {g,f,e,d,c,b,a}, 1 = lit
   function automatic logic [6:0] hex_enc(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign disp_data   = disp_q[DAT_W-1:0];
   assign disp_dp     = disp_q[BUF_W-1:DAT_W];
   assign cur_nib     = disp_data[{idx_q, 2'b00} +: 4];
   assign slot_end    = (cnt_q == CNT_LAST);
   assign dbg_state_o = state_q;
   assign bus.SEG     = seg_q;
   assign bus.AN      = an_q;

`ifdef SEG_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_mask;

   // Leading-zero mask from the display buffer: digit k is blanked when it and
   // every digit above it hold 0 with no dp set; digit 0 always shows
   always_comb begin
      logic zero_run;
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run & (disp_data[4*k +: 4] == 4'h0) & ~disp_dp[k];
         lz_mask[k] = zero_run;
      end
   end
`endif

   // Scan counters, slot phase next-state and buffer updates
   always_comb begin
      cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      state_d = ST_SHOW;
      pend_d  = pend_q;
      disp_d  = disp_q;
      if (slot_end) begin
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         // Commit uses pending as it stood before this cycle's load
         disp_d = pend_q;
      end
      if ((GAP_CYC > 0) && (cnt_d < GAP_END)) begin
         state_d = ST_GAP;
      end
      if (bus.load) begin
         pend_d = {bus.dp_in, bus.data_in};
      end
   end

   // Logical (active-high) pin values for the current cycle, polarity applied last
   always_comb begin
      seg_lit = '0;
      an_lit  = '0;
      if (state_q == ST_SHOW) begin
         seg_lit[6:0] = hex_enc(cur_nib);
         seg_lit[7]   = disp_dp[idx_q];
`ifdef SEG_LZ_BLANK_EN
         if (lz_mask[idx_q]) begin
            seg_lit[6:0] = '0;
         end
`endif
         an_lit[idx_q] = bus.digit_en[idx_q];
      end
      seg_d = (ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
      an_d  = (ACTIVE_LOW != 0) ? ~an_lit  : an_lit;
   end

   // State, buffer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= ST_FIRST;
         pend_q  <= '0;
         disp_q  <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

endmodule
